// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-condition encodings and helpers for the branch resolve unit.
package branch_resolve_unit_pkg;

  localparam int BRU_CTRL_W = 4;

  typedef enum logic [BRU_CTRL_W-1:0] {
    BCU_EQ  = 4'd0,
    BCU_NE  = 4'd1,
    BCU_GT  = 4'd2,
    BCU_LT  = 4'd3,
    BCU_GE  = 4'd4,
    BCU_LE  = 4'd5,
    BCU_EQZ = 4'd6,
    BCU_NEZ = 4'd7,
    BCU_GTZ = 4'd8,
    BCU_LTZ = 4'd9,
    BCU_GEZ = 4'd10,
    BCU_LEZ = 4'd11
  } bcu_ctrl_e;

  // True for the codes that compare rd1 against zero instead of rd2.
  function automatic logic bcu_is_zero_form(input logic [BRU_CTRL_W-1:0] code);
    return (code >= BCU_EQZ) && (code <= BCU_LEZ);
  endfunction

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational branch condition evaluator: (ctrl, is_signed, rd1, rd2) -> (taken, bad_ctrl).
module bru_cond_eval
  import branch_resolve_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [BRU_CTRL_W-1:0] ctrl,
  input  logic                  is_signed,
  input  logic [WIDTH-1:0]      rd1,
  input  logic [WIDTH-1:0]      rd2,
  output logic                  taken,
  output logic                  bad_ctrl
);

  logic             zero_form;
  logic [WIDTH-1:0] opnd_b;
  logic             eq;
  logic             lt;

  // Zero-form codes reuse the two-operand comparators with operand B forced to 0,
  // which makes unsigned LTZ/GEZ fall out as constant 0/1 naturally.
  assign zero_form = bcu_is_zero_form(ctrl);
  assign opnd_b    = zero_form ? '0 : rd2;
  assign eq        = (rd1 == opnd_b);
  assign lt        = is_signed ? ($signed(rd1) < $signed(opnd_b)) : (rd1 < opnd_b);

  always_comb begin
    taken    = 1'b0;
    bad_ctrl = 1'b0;
    case (bcu_ctrl_e'(ctrl))
      BCU_EQ,  BCU_EQZ: taken = eq;
      BCU_NE,  BCU_NEZ: taken = !eq;
      BCU_GT,  BCU_GTZ: taken = !lt && !eq;
      BCU_LT,  BCU_LTZ: taken = lt;
      BCU_GE,  BCU_GEZ: taken = !lt;
      BCU_LE,  BCU_LEZ: taken = lt || eq;
      default:          bad_ctrl = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: condition evaluation, redirect generation and
// saturating branch/mispredict statistics, with a 1- or 2-stage pipeline.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PC_WIDTH  = 32,
  parameter int STAGES    = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [BRU_CTRL_W-1:0] ctrl,
  input  logic                  is_signed,
  input  logic [WIDTH-1:0]      rd1,
  input  logic [WIDTH-1:0]      rd2,
  input  logic                  pred_taken,
  input  logic [PC_WIDTH-1:0]   target_pc,
  input  logic [PC_WIDTH-1:0]   fallthru_pc,
  output logic                  out_valid,
  output logic                  taken,
  output logic                  mispredict,
  output logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  bad_ctrl,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispred_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("branch_resolve_unit: STAGES must be 1 or 2, got %0d", STAGES);
  end

  logic                  s1_valid;
  logic [BRU_CTRL_W-1:0] s1_ctrl;
  logic                  s1_signed;
  logic [WIDTH-1:0]      s1_rd1;
  logic [WIDTH-1:0]      s1_rd2;
  logic                  s1_pred;
  logic [PC_WIDTH-1:0]   s1_target;
  logic [PC_WIDTH-1:0]   s1_fallthru;

  // With two stages the operands are registered first; with one stage the
  // evaluator sees the inputs directly and only its result is registered.
  if (STAGES == 2) begin : g_stage1_reg
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid    <= 1'b0;
        s1_ctrl     <= '0;
        s1_signed   <= 1'b0;
        s1_rd1      <= '0;
        s1_rd2      <= '0;
        s1_pred     <= 1'b0;
        s1_target   <= '0;
        s1_fallthru <= '0;
      end else if (flush) begin
        s1_valid <= 1'b0;
      end else if (!stall) begin
        s1_valid    <= in_valid;
        s1_ctrl     <= ctrl;
        s1_signed   <= is_signed;
        s1_rd1      <= rd1;
        s1_rd2      <= rd2;
        s1_pred     <= pred_taken;
        s1_target   <= target_pc;
        s1_fallthru <= fallthru_pc;
      end
    end
  end else begin : g_stage1_pass
    assign s1_valid    = in_valid;
    assign s1_ctrl     = ctrl;
    assign s1_signed   = is_signed;
    assign s1_rd1      = rd1;
    assign s1_rd2      = rd2;
    assign s1_pred     = pred_taken;
    assign s1_target   = target_pc;
    assign s1_fallthru = fallthru_pc;
  end

  logic eval_taken;
  logic eval_bad;

  bru_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
    .ctrl     (s1_ctrl),
    .is_signed(s1_signed),
    .rd1      (s1_rd1),
    .rd2      (s1_rd2),
    .taken    (eval_taken),
    .bad_ctrl (eval_bad)
  );

  logic                out_valid_q;
  logic                taken_q;
  logic                bad_q;
  logic                pred_q;
  logic [PC_WIDTH-1:0] redirect_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      bad_q       <= 1'b0;
      pred_q      <= 1'b0;
      redirect_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= s1_valid;
      taken_q     <= eval_taken;
      bad_q       <= eval_bad;
      pred_q      <= s1_pred;
      redirect_q  <= eval_taken ? s1_target : s1_fallthru;
    end
  end

  // Status flags are masked so stale data in an invalid stage never leaks out.
  assign out_valid   = out_valid_q;
  assign taken       = out_valid_q & taken_q;
  assign mispredict  = out_valid_q & (taken_q ^ pred_q);
  assign bad_ctrl    = out_valid_q & bad_q;
  assign redirect_pc = redirect_q;

  // An op already on the outputs is counted even if a flush lands this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count  <= '0;
      mispred_count <= '0;
    end else if (!stall) begin
      if (out_valid_q && (branch_count != '1))
        branch_count <= branch_count + CNT_ONE;
      if (mispredict && (mispred_count != '1))
        mispred_count <= mispred_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one-stage, two-stage and narrow-counter instances share stimulus.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [3:0]  ctrl;
  logic        is_signed;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        pred_taken;
  logic [31:0] target_pc;
  logic [31:0] fallthru_pc;

  logic        o1_valid, o1_taken, o1_mis, o1_bad;
  logic [31:0] o1_redir, o1_bcnt, o1_mcnt;
  logic        o2_valid, o2_taken, o2_mis, o2_bad;
  logic [31:0] o2_redir, o2_bcnt, o2_mcnt;
  logic        o3_valid, o3_taken, o3_mis, o3_bad;
  logic [31:0] o3_redir;
  logic [3:0]  o3_bcnt, o3_mcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .PC_WIDTH(32), .STAGES(1), .CNT_WIDTH(32)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ctrl(ctrl), .is_signed(is_signed), .rd1(rd1), .rd2(rd2), .pred_taken(pred_taken),
    .target_pc(target_pc), .fallthru_pc(fallthru_pc), .out_valid(o1_valid), .taken(o1_taken),
    .mispredict(o1_mis), .redirect_pc(o1_redir), .bad_ctrl(o1_bad),
    .branch_count(o1_bcnt), .mispred_count(o1_mcnt));

  branch_resolve_unit #(.WIDTH(32), .PC_WIDTH(32), .STAGES(2), .CNT_WIDTH(32)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ctrl(ctrl), .is_signed(is_signed), .rd1(rd1), .rd2(rd2), .pred_taken(pred_taken),
    .target_pc(target_pc), .fallthru_pc(fallthru_pc), .out_valid(o2_valid), .taken(o2_taken),
    .mispredict(o2_mis), .redirect_pc(o2_redir), .bad_ctrl(o2_bad),
    .branch_count(o2_bcnt), .mispred_count(o2_mcnt));

  branch_resolve_unit #(.WIDTH(32), .PC_WIDTH(32), .STAGES(1), .CNT_WIDTH(4)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .ctrl(ctrl), .is_signed(is_signed), .rd1(rd1), .rd2(rd2), .pred_taken(pred_taken),
    .target_pc(target_pc), .fallthru_pc(fallthru_pc), .out_valid(o3_valid), .taken(o3_taken),
    .mispredict(o3_mis), .redirect_pc(o3_redir), .bad_ctrl(o3_bad),
    .branch_count(o3_bcnt), .mispred_count(o3_mcnt));

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        exp_taken;
    logic        exp_mis;
    logic        exp_bad;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic s,
                               input logic [31:0] a, input logic [31:0] b, input logic p,
                               input logic [31:0] tgt, input logic [31:0] ft);
    in_valid    = v;
    ctrl        = c;
    is_signed   = s;
    rd1         = a;
    rd2         = b;
    pred_taken  = p;
    target_pc   = tgt;
    fallthru_pc = ft;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_mcnt;
    vecs[0]  = '{4'd3,  1'b1, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'd3,  1'b0, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd0,  1'b1, 32'd5,        32'd5,        1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'd1,  1'b1, 32'd5,        32'd5,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'd2,  1'b1, 32'd7,        32'hFFFFFFF9, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{4'd2,  1'b0, 32'd7,        32'hFFFFFFF9, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd4,  1'b1, 32'd3,        32'd3,        1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'd5,  1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{4'd5,  1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd6,  1'b1, 32'd0,        32'd123,      1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'd7,  1'b1, 32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd8,  1'b1, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd8,  1'b0, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'd9,  1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{4'd9,  1'b0, 32'h80000000, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'd10, 1'b0, 32'h80000000, 32'd0,        1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{4'd10, 1'b1, 32'h80000000, 32'd0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{4'd11, 1'b1, 32'd0,        32'd9,        1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{4'd11, 1'b0, 32'd1,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{4'd15, 1'b1, 32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{4'd12, 1'b1, 32'd5,        32'd5,        1'b1, 1'b0, 1'b1, 1'b1};

    // Reset held 3 cycles with a live op on the inputs: reset must win.
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b1, 4'd0, 1'b1, 32'd1, 32'd1, 1'b0, 32'h10, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rst%0d_u1_valid", i), {31'd0, o1_valid}, 32'd0);
      checkOutput($sformatf("rst%0d_u2_valid", i), {31'd0, o2_valid}, 32'd0);
      checkOutput($sformatf("rst%0d_u1_redir", i), o1_redir, 32'd0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("post_rst_flags", {28'd0, o1_valid, o1_taken, o1_mis, o1_bad}, 32'd0);
    checkOutput("post_rst_bcnt", o1_bcnt, 32'd0);
    checkOutput("post_rst_mcnt", o2_mcnt, 32'd0);

    // Table of single-stage vectors streamed back to back.
    exp_mcnt = 0;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b1, vecs[i].ctrl, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].pred,
                    32'h100 + 32'(i * 16), 32'h44 + 32'(i * 16));
      tick();
      checkOutput($sformatf("v%0d_valid", i), {31'd0, o1_valid}, 32'd1);
      checkOutput($sformatf("v%0d_taken", i), {31'd0, o1_taken}, {31'd0, vecs[i].exp_taken});
      checkOutput($sformatf("v%0d_mis", i), {31'd0, o1_mis}, {31'd0, vecs[i].exp_mis});
      checkOutput($sformatf("v%0d_bad", i), {31'd0, o1_bad}, {31'd0, vecs[i].exp_bad});
      checkOutput($sformatf("v%0d_redir", i), o1_redir,
                  vecs[i].exp_taken ? 32'h100 + 32'(i * 16) : 32'h44 + 32'(i * 16));
      checkOutput($sformatf("v%0d_bcnt", i), o1_bcnt, 32'(i));
      checkOutput($sformatf("v%0d_mcnt", i), o1_mcnt, 32'(exp_mcnt));
      if (vecs[i].exp_mis) exp_mcnt++;
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("tbl_idle_flags", {28'd0, o1_valid, o1_taken, o1_mis, o1_bad}, 32'd0);
    checkOutput("tbl_bcnt", o1_bcnt, 32'd21);
    checkOutput("tbl_mcnt", o1_mcnt, 32'd8);
    checkOutput("tbl_u3_bcnt_sat", {28'd0, o3_bcnt}, 32'hF);
    checkOutput("tbl_u3_mcnt", {28'd0, o3_mcnt}, 32'd8);

    // Two-stage back-to-back EQ then NE.
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b1, 32'd5, 32'd5, 1'b1, 32'h500, 32'h504);
    tick();
    checkOutput("s2_lat_valid", {31'd0, o2_valid}, 32'd0);
    applyStimulus(1'b1, 4'd1, 1'b1, 32'd5, 32'd5, 1'b1, 32'h600, 32'h604);
    tick();
    checkOutput("s2_eq_valid", {31'd0, o2_valid}, 32'd1);
    checkOutput("s2_eq_taken", {31'd0, o2_taken}, 32'd1);
    checkOutput("s2_eq_redir", o2_redir, 32'h500);
    checkOutput("s2_eq_bcnt", o2_bcnt, 32'd0);
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("s2_ne_valid", {31'd0, o2_valid}, 32'd1);
    checkOutput("s2_ne_taken", {31'd0, o2_taken}, 32'd0);
    checkOutput("s2_ne_mis", {31'd0, o2_mis}, 32'd1);
    checkOutput("s2_ne_redir", o2_redir, 32'h604);
    checkOutput("s2_ne_bcnt", o2_bcnt, 32'd1);
    tick();
    checkOutput("s2_idle_valid", {31'd0, o2_valid}, 32'd0);
    checkOutput("s2_final_bcnt", o2_bcnt, 32'd2);
    checkOutput("s2_final_mcnt", o2_mcnt, 32'd1);

    // Two-stage stall: op A on the outputs, op B in stage 1, three stalled cycles.
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b1, 32'd1, 32'd1, 1'b1, 32'h200, 32'h204);
    tick();
    applyStimulus(1'b1, 4'd2, 1'b1, 32'd9, 32'd2, 1'b0, 32'h300, 32'h304);
    tick();
    checkOutput("stl_a_taken", {31'd0, o2_taken}, 32'd1);
    stall = 1'b1;
    applyStimulus(1'b1, 4'd1, 1'b1, 32'd1, 32'd1, 1'b0, 32'h999, 32'h998);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stl%0d_valid", i), {31'd0, o2_valid}, 32'd1);
      checkOutput($sformatf("stl%0d_redir", i), o2_redir, 32'h200);
      checkOutput($sformatf("stl%0d_bcnt", i), o2_bcnt, 32'd0);
    end
    stall = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("stl_b_valid", {31'd0, o2_valid}, 32'd1);
    checkOutput("stl_b_redir", o2_redir, 32'h300);
    checkOutput("stl_b_mis", {31'd0, o2_mis}, 32'd1);
    checkOutput("stl_b_bcnt", o2_bcnt, 32'd1);
    tick();
    checkOutput("stl_c_dropped", {31'd0, o2_valid}, 32'd0);
    checkOutput("stl_end_bcnt", o2_bcnt, 32'd2);

    // Flush together with a new op while one op is in flight.
    doReset();
    applyStimulus(1'b1, 4'd0, 1'b1, 32'd1, 32'd1, 1'b0, 32'h700, 32'h704);
    tick();
    flush = 1'b1;
    applyStimulus(1'b1, 4'd1, 1'b1, 32'd1, 32'd2, 1'b0, 32'h800, 32'h804);
    tick();
    checkOutput("fl_u2_valid", {31'd0, o2_valid}, 32'd0);
    checkOutput("fl_u2_flags", {29'd0, o2_taken, o2_mis, o2_bad}, 32'd0);
    checkOutput("fl_u1_valid", {31'd0, o1_valid}, 32'd0);
    checkOutput("fl_u1_counted", o1_bcnt, 32'd1);
    checkOutput("fl_u1_mcnt", o1_mcnt, 32'd1);
    flush = 1'b0;
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("fl_u2_after", {31'd0, o2_valid}, 32'd0);
    checkOutput("fl_u2_bcnt", o2_bcnt, 32'd0);

    // Saturation of the 4-bit mispredict counter.
    doReset();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 4'd3, 1'b1, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h100, 32'h44);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("sat_u3_mcnt_full", {28'd0, o3_mcnt}, 32'hF);
    checkOutput("sat_u1_mcnt_15", o1_mcnt, 32'd15);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 4'd3, 1'b1, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h100, 32'h44);
      tick();
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    tick();
    checkOutput("sat_u3_mcnt_hold", {28'd0, o3_mcnt}, 32'hF);
    checkOutput("sat_u3_bcnt_hold", {28'd0, o3_bcnt}, 32'hF);
    checkOutput("sat_u1_mcnt_17", o1_mcnt, 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
